round_pipe: RTL
===============

ROUND_PIPE -- requirements
Module: round_pipe

Interface
REQ-001 Parameter W_IN, default 27: unrounded significand width, normalised, MSB is the hidden bit.
REQ-002 Parameter W_OUT, default 24: rounded significand width, hidden bit included; W_IN >= W_OUT+2 SHALL hold.
REQ-003 Parameter W_EXP, default 8: biased exponent width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input beat present.
REQ-007 in_ready  out  1  block accepts beat this cycle.
REQ-008 mode  in  3  001 RTZ, 010 RDN, 011 RUP, 100 RMM, any other code RNE.
REQ-009 sign  in  1  operand sign.
REQ-010 exp_in  in  W_EXP  biased exponent, all-ones never presented.
REQ-011 d_in  in  W_IN  significand.
REQ-012 sticky_in  in  1  OR of bits already discarded upstream.
REQ-013 out_valid  out  1  result beat present.
REQ-014 out_ready  in  1  downstream accepts beat.
REQ-015 d_out  out  W_OUT  rounded significand.
REQ-016 exp_out  out  W_EXP  result exponent.
REQ-017 sign_out  out  1  registered sign.
REQ-018 inexact  out  1  result differs from exact value.
REQ-019 overflow  out  1  exponent overflowed after rounding.

Function
REQ-020 Two-stage pipeline; an accepted beat SHALL appear on out_valid exactly 2 cycles later absent stall.
REQ-021 Advance enable en = out_ready OR NOT out_valid; in_ready SHALL equal en; on en both stages shift, otherwise all stage registers hold.
REQ-022 A beat SHALL be accepted only when in_valid AND in_ready; bubbles propagate as valid=0.
REQ-023 Stage 1 SHALL register lsb = d_in[W_IN-W_OUT], g = d_in[W_IN-W_OUT-1], r = OR(d_in[W_IN-W_OUT-2:0]) OR sticky_in, the truncated significand, exponent, sign and the increment decision.
REQ-024 Increment: RTZ 0; RNE g AND (r OR lsb); RMM g; RUP NOT sign AND (g OR r); RDN sign AND (g OR r).
REQ-025 inexact SHALL equal g OR r, independent of mode.
REQ-026 Stage 2 SHALL add the increment to the W_OUT-bit truncation with a carry bit.
REQ-027 On carry: d_out = 1 followed by W_OUT-1 zeros, exp_out = exp+1.
REQ-028 Overflow SHALL be set when post-rounding exponent equals all-ones.
REQ-029 On overflow, RNE, RMM, RUP with sign=0 and RDN with sign=1 SHALL output infinity: exp_out all-ones, d_out 0.
REQ-030 On overflow, any other mode/sign combination SHALL output max finite: exp_out all-ones minus 1, d_out all-ones; inexact=1.
REQ-031 mode and sign are sampled with the beat; mode changes never affect beats already in flight.

Reset
REQ-032 While rst=1 at a clock edge, both stage valid flags SHALL clear and every output register SHALL become 0 (out_valid, d_out, exp_out, sign_out, inexact, overflow).
REQ-033 in_ready SHALL be 1 during the cycle after reset.
REQ-034 Reset mid-stall SHALL discard in-flight beats; none reappear.

Structure
REQ-035 Rounding-mode codes (RTZ, RDN, RUP, RMM, RNE) SHALL live in the shared FPU package and be used by every rounding consumer.
REQ-036 Increment-decision logic SHALL be a sub-module round_decide (inputs mode, sign, lsb, g, r; outputs inc, inexact), reusable by the FMA path.

Verification
REQ-037 RNE tie, even: d_in=0x0000004 (g=1, r=0, lsb=0), exp=0x80 -> d_out=0x000000, inexact=1, overflow=0, 2 cycles after accept.
REQ-038 RNE tie, odd, carry: d_in=0x7FFFFFC, exp=0x80 -> d_out=0x800000, exp_out=0x81, inexact=1.
REQ-039 Overflow: d_in=0x7FFFFFF, exp=0xFE, sign=0; RNE -> exp_out=0xFF, d_out=0, overflow=1; RTZ -> exp_out=0xFE, d_out=0xFFFFFF, overflow=0; RDN sign=0 -> max finite, overflow=0.
REQ-040 Directed-mode sweep: d_in=0x4000003, sticky_in=1, both signs, all 5 modes -> inc per REQ-024, inexact=1 throughout.
REQ-041 Backpressure: 4 back-to-back beats, out_ready low 3 cycles after first output -> in_ready low while stalled, outputs stable, all 4 delivered in order, none lost or duplicated.
REQ-042 Reset with 2 beats in flight -> out_valid=0 next cycle, all outputs 0, no stale beat emitted.

Source files
------------

// File: rtl/round_pipe_pkg.sv
// Shared FPU rounding definitions: mode codes and helpers used by every rounding consumer.
// Codes outside the named set decode to round-to-nearest-even.
package round_pipe_pkg;

   typedef enum logic [2:0] {
      RmRne = 3'b000,
      RmRtz = 3'b001,
      RmRdn = 3'b010,
      RmRup = 3'b011,
      RmRmm = 3'b100
   } round_mode_e;

   function automatic round_mode_e decode_mode(input logic [2:0] code);
      round_mode_e m;
      case (code)
         3'b001:  m = RmRtz;
         3'b010:  m = RmRdn;
         3'b011:  m = RmRup;
         3'b100:  m = RmRmm;
         default: m = RmRne;
      endcase
      return m;
   endfunction

   // Modes that round away from zero in the operand's direction saturate to infinity.
   function automatic logic overflow_to_inf(input round_mode_e m, input logic sign);
      logic inf;
      case (m)
         RmRne:   inf = 1'b1;
         RmRmm:   inf = 1'b1;
         RmRup:   inf = ~sign;
         RmRdn:   inf = sign;
         default: inf = 1'b0;
      endcase
      return inf;
   endfunction

endpackage

// File: rtl/round_decide.sv
// Rounding increment decision from lsb/guard/round-sticky bits; shared with the FMA path.
module round_decide
   import round_pipe_pkg::*;
(
   input  logic [2:0] mode,
   input  logic       sign,
   input  logic       lsb,
   input  logic       g,
   input  logic       r,
   output logic       inc,
   output logic       inexact
);

   always_comb begin
      inc = 1'b0;
      case (decode_mode(mode))
         RmRtz:   inc = 1'b0;
         RmRne:   inc = g & (r | lsb);
         RmRmm:   inc = g;
         RmRup:   inc = ~sign & (g | r);
         RmRdn:   inc = sign & (g | r);
         default: inc = 1'b0;
      endcase
   end

   assign inexact = g | r;

endmodule

// File: rtl/round_pipe.sv
// Two-stage significand rounding pipeline with valid/ready flow control.
// Stage 1 extracts rounding bits and decides the increment; stage 2 adds it and handles overflow.
module round_pipe
   import round_pipe_pkg::*;
#(
   parameter int unsigned W_IN  = 27,
   parameter int unsigned W_OUT = 24,
   parameter int unsigned W_EXP = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       mode,
   input  logic             sign,
   input  logic [W_EXP-1:0] exp_in,
   input  logic [W_IN-1:0]  d_in,
   input  logic             sticky_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] d_out,
   output logic [W_EXP-1:0] exp_out,
   output logic             sign_out,
   output logic             inexact,
   output logic             overflow
);

   localparam int unsigned Shift = W_IN - W_OUT;

   logic en;

   logic lsb_in, g_in, r_in;
   logic inc_in, inexact_in;

   logic             s1_valid_q;
   logic [W_OUT-1:0] s1_trunc_q;
   logic [W_EXP-1:0] s1_exp_q;
   logic             s1_sign_q;
   logic             s1_inc_q;
   logic             s1_inexact_q;
   logic             s1_to_inf_q;

   logic [W_OUT:0]   sum;
   logic [W_OUT-1:0] d_rnd, d_fin;
   logic [W_EXP-1:0] exp_rnd, exp_fin;
   logic             ovf;

   // Both stages move together; a full output stage blocks until drained.
   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   assign lsb_in = d_in[Shift];
   assign g_in   = d_in[Shift-1];
   assign r_in   = (|d_in[Shift-2:0]) | sticky_in;

   round_decide u_round_decide (
      .mode    (mode),
      .sign    (sign),
      .lsb     (lsb_in),
      .g       (g_in),
      .r       (r_in),
      .inc     (inc_in),
      .inexact (inexact_in)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_trunc_q   <= '0;
         s1_exp_q     <= '0;
         s1_sign_q    <= 1'b0;
         s1_inc_q     <= 1'b0;
         s1_inexact_q <= 1'b0;
         s1_to_inf_q  <= 1'b0;
      end else if (en) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_trunc_q   <= d_in[W_IN-1:Shift];
            s1_exp_q     <= exp_in;
            s1_sign_q    <= sign;
            s1_inc_q     <= inc_in;
            s1_inexact_q <= inexact_in;
            s1_to_inf_q  <= overflow_to_inf(decode_mode(mode), sign);
         end
      end
   end

   assign sum = {1'b0, s1_trunc_q} + {{W_OUT{1'b0}}, s1_inc_q};

   always_comb begin
      d_rnd   = sum[W_OUT-1:0];
      exp_rnd = s1_exp_q;
      // Carry out renormalises: significand becomes 1.000..0 and exponent bumps.
      if (sum[W_OUT]) begin
         d_rnd   = {1'b1, {(W_OUT-1){1'b0}}};
         exp_rnd = s1_exp_q + W_EXP'(1);
      end
      ovf     = &exp_rnd;
      d_fin   = d_rnd;
      exp_fin = exp_rnd;
      if (ovf) begin
         if (s1_to_inf_q) begin
            exp_fin = '1;
            d_fin   = '0;
         end else begin
            exp_fin = {{(W_EXP-1){1'b1}}, 1'b0};
            d_fin   = '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         d_out     <= '0;
         exp_out   <= '0;
         sign_out  <= 1'b0;
         inexact   <= 1'b0;
         overflow  <= 1'b0;
      end else if (en) begin
         out_valid <= s1_valid_q;
         if (s1_valid_q) begin
            d_out    <= d_fin;
            exp_out  <= exp_fin;
            sign_out <= s1_sign_q;
            inexact  <= s1_inexact_q | ovf;
            overflow <= ovf;
         end
      end
   end

endmodule
